instruction_fetch: RTL and testbench

// - IF stage of the 5-stage MIPS pipeline: holds the PC and a word-addressed instruction memory.
// - Drives the IF/ID pipeline register (o_pc4, o_instruction) consumed by the decode stage.
// - Obeys the hazard-unit stall and the branch redirect (i_jump / i_jump_addr) resolved in ID.
// - The debug unit loads the program via a memory write port and gates execution with i_enable.

---
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   IF stage of the 5-stage MIPS pipeline. Holds the PC and a word-addressed
//   instruction memory, and drives the IF/ID pipeline register for decode.
//
//   Optional feature macro: IF_HALT_DETECT_EN
//     defined   -> fetching 32'hFFFFFFFF latches it, sets a sticky o_halt and
//                  parks the PC on the halt word (a same-cycle jump wins)
//     undefined -> o_halt is tied low; 32'hFFFFFFFF is an ordinary word
//
//   Ports
//     i_clk, i_reset    clock / async active-high reset
//     i_enable          1 = pipeline advances, 0 = all IF state holds
//     i_stall           hazard-unit stall: PC and IF/ID hold, jump ignored
//     i_jump            taken branch from ID (same cycle)
//     i_jump_addr       branch target
//     i_imem_wr_*       debug loader write port (synchronous)
//     o_pc              current PC
//     o_pc4             IF/ID: PC+4 of the latched instruction
//     o_instruction     IF/ID: latched instruction
//     o_halt            halt reached
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int NB_PC     = 32,
    parameter int NB_INSTR  = 32,
    parameter int MEM_DEPTH = 256,
    localparam int AW       = $clog2(MEM_DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_stall,
    input  logic                i_jump,
    input  logic [NB_PC-1:0]    i_jump_addr,
    input  logic                i_imem_wr_en,
    input  logic [AW-1:0]       i_imem_wr_addr,
    input  logic [NB_INSTR-1:0] i_imem_wr_data,
    output logic [NB_PC-1:0]    o_pc,
    output logic [NB_PC-1:0]    o_pc4,
    output logic [NB_INSTR-1:0] o_instruction,
    output logic                o_halt
);

    logic [NB_INSTR-1:0] imem [MEM_DEPTH];
    logic [NB_PC-1:0]    pc_q;
    logic [NB_PC-1:0]    pc_plus4;
    logic [NB_INSTR-1:0] fetch_word;
    logic                halt_q;
    logic                is_halt_word;
    logic                advance;

    // Memory is never cleared by reset; the loader owns its contents.
    // A same-edge write and fetch returns the old word because the fetch
    // path below reads the array combinationally before the edge commits.
    always_ff @(posedge i_clk) begin
        if (i_imem_wr_en)
            imem[i_imem_wr_addr] <= i_imem_wr_data;
    end

    // PC[1:0] is ignored for indexing; upper bits alias.
    assign fetch_word = imem[pc_q[AW+1:2]];
    assign pc_plus4   = pc_q + NB_PC'(4);
    assign advance    = i_enable && !halt_q && !i_stall;

`ifdef IF_HALT_DETECT_EN
    assign is_halt_word = (fetch_word == {NB_INSTR{1'b1}});

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            halt_q <= 1'b0;
        else if (advance && !i_jump && is_halt_word)
            halt_q <= 1'b1;
    end
`else
    assign is_halt_word = 1'b0;
    assign halt_q       = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q          <= '0;
            o_pc4         <= '0;
            o_instruction <= '0;
        end else if (advance) begin
            if (i_jump) begin
                // Flush the wrong-path fetch; there is no delay slot.
                pc_q          <= i_jump_addr;
                o_pc4         <= '0;
                o_instruction <= '0;
            end else begin
                o_instruction <= fetch_word;
                o_pc4         <= pc_plus4;
                // A halt word parks the PC on itself.
                if (!is_halt_word)
                    pc_q <= pc_plus4;
            end
        end
    end

    assign o_pc   = pc_q;
    assign o_halt = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Directed scenarios with literal expectations followed by a randomized run.
//   A behavioural model (array memory + PC arithmetic) is advanced on every
//   posedge; a negedge process compares every DUT output against it.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_enable = 1'b0;
    logic          i_stall = 1'b0;
    logic          i_jump = 1'b0;
    logic [31:0]   i_jump_addr = '0;
    logic          i_imem_wr_en = 1'b0;
    logic [AW-1:0] i_imem_wr_addr = '0;
    logic [31:0]   i_imem_wr_data = '0;
    logic [31:0]   o_pc, o_pc4, o_instruction;
    logic          o_halt;

    instruction_fetch #(.NB_PC(32), .NB_INSTR(32), .MEM_DEPTH(256)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
        .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_imem_wr_en(i_imem_wr_en),
        .i_imem_wr_addr(i_imem_wr_addr), .i_imem_wr_data(i_imem_wr_data),
        .o_pc(o_pc), .o_pc4(o_pc4), .o_instruction(o_instruction), .o_halt(o_halt)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [256];
    logic [31:0] pre   [256];
    logic [31:0] m_pc = '0, m_pc4 = '0, m_instr = '0;
    logic        m_halt = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_pc4 = '0; m_instr = '0; m_halt = 1'b0;
    endtask

    // Applies one clock edge of the IF rules using the inputs present at the edge.
    task automatic model_edge();
        logic [31:0] word;
        word = m_mem[m_pc[AW+1:2]];
        if (i_enable && !m_halt && !i_stall) begin
            if (i_jump) begin
                m_pc = i_jump_addr; m_instr = '0; m_pc4 = '0;
            end else begin
                m_instr = word;
                m_pc4   = m_pc + 32'd4;
`ifdef IF_HALT_DETECT_EN
                if (word == 32'hFFFF_FFFF) m_halt = 1'b1;
                else m_pc = m_pc + 32'd4;
`else
                m_pc = m_pc + 32'd4;
`endif
            end
        end
        if (i_imem_wr_en) m_mem[i_imem_wr_addr] = i_imem_wr_data;
    endtask

    always @(negedge i_clk) begin
        chk("pc", o_pc, m_pc);
        chk("pc4", o_pc4, m_pc4);
        chk("instr", o_instruction, m_instr);
        chk("halt", {31'd0, o_halt}, {31'd0, m_halt});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        i_enable = 1'b0; i_imem_wr_en = 1'b1;
        i_imem_wr_addr = AW'(a); i_imem_wr_data = d;
        step();
        i_imem_wr_en = 1'b0;
    endtask

    task automatic run(input int n);
        i_enable = 1'b1; i_stall = 1'b0; i_jump = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic jump(input logic [31:0] a);
        i_enable = 1'b1; i_stall = 1'b0; i_jump = 1'b1; i_jump_addr = a;
        step();
        i_jump = 1'b0;
    endtask

    // Async pulse between edges; called just after a posedge.
    task automatic pulse_reset();
        i_reset = 1'b1;
        #1;
        model_reset();
        i_reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] d;
        model_reset();
        #3;
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_instr", o_instruction, 32'h0);
        chk("rst_pc4", o_pc4, 32'h0);
        chk("rst_halt", {31'd0, o_halt}, 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;

        // Preload the whole memory with known values.
        for (int a = 0; a < 256; a++) begin
            d = $urandom;
            if (d == 32'hFFFF_FFFF) d = 32'h0;
            pre[a] = d;
            wr(a, d);
        end
        wr(0, 32'h11); wr(1, 32'h22); wr(2, 32'h33); wr(3, 32'h44); wr(16, 32'h55);

        // Sequential fetch and stall
        pulse_reset();
        run(1);
        chk("seq1_instr", o_instruction, 32'h11); chk("seq1_pc4", o_pc4, 32'd4);
        run(1);
        chk("seq2_instr", o_instruction, 32'h22); chk("seq2_pc4", o_pc4, 32'd8);
        i_stall = 1'b1; step(); step(); i_stall = 1'b0;
        chk("stall_pc", o_pc, 32'd8); chk("stall_instr", o_instruction, 32'h22);
        run(1);
        chk("seq3_instr", o_instruction, 32'h33); chk("seq3_pc4", o_pc4, 32'd12);
        chk("seq3_pc", o_pc, 32'd12);

        // Branch, then stall+jump
        pulse_reset();
        run(2);
        jump(32'h40);
        chk("br_instr", o_instruction, 32'h0); chk("br_pc", o_pc, 32'h40);
        chk("br_pc4", o_pc4, 32'h0);
        run(1);
        chk("br_tgt_instr", o_instruction, 32'h55); chk("br_tgt_pc4", o_pc4, 32'h44);
        i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 32'h80; step();
        i_stall = 1'b0; i_jump = 1'b0;
        chk("stalljmp_pc", o_pc, 32'h44); chk("stalljmp_instr", o_instruction, 32'h55);

        // PC wrap, address aliasing, unaligned PC
        jump(32'hFFFF_FFFC); run(1);
        chk("wrap_pc", o_pc, 32'h0); chk("wrap_pc4", o_pc4, 32'h0);
        chk("wrap_instr", o_instruction, pre[255]);
        jump(32'h400); run(1);
        chk("alias_instr", o_instruction, 32'h11); chk("alias_pc4", o_pc4, 32'h404);
        jump(32'h41); run(1);
        chk("unal_instr", o_instruction, 32'h55); chk("unal_pc4", o_pc4, 32'h45);

        // Same-cycle write and fetch of word 17: old word first, new word later
        i_imem_wr_en = 1'b1; i_imem_wr_addr = 8'd17; i_imem_wr_data = 32'hABCD;
        run(1);
        i_imem_wr_en = 1'b0;
        chk("rw_old", o_instruction, pre[17]);
        jump(32'h44); run(1);
        chk("rw_new", o_instruction, 32'hABCD);

        // Reset mid-run
        pulse_reset();
        run(8);
        chk("mid_pc", o_pc, 32'h20);
        i_reset = 1'b1;
        #1;
        chk("midrst_pc", o_pc, 32'h0); chk("midrst_instr", o_instruction, 32'h0);
        model_reset();
        i_reset = 1'b0;
        run(1);
        chk("mem_kept", o_instruction, 32'h11);

        // Halt word at address 3
        wr(3, 32'hFFFF_FFFF);
        pulse_reset();
        run(4);
        chk("halt_instr", o_instruction, 32'hFFFF_FFFF);
`ifdef IF_HALT_DETECT_EN
        chk("halt_flag", {31'd0, o_halt}, 32'd1); chk("halt_pc", o_pc, 32'd12);
        run(10);
        chk("halt_pc_hold", o_pc, 32'd12); chk("halt_sticky", {31'd0, o_halt}, 32'd1);
`else
        chk("nohalt_flag", {31'd0, o_halt}, 32'd0); chk("nohalt_pc", o_pc, 32'd16);
`endif
        wr(3, 32'h44);

        // Randomized run
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            i_enable       = ($urandom_range(0, 9) < 8);
            i_stall        = ($urandom_range(0, 9) < 2);
            i_jump         = ($urandom_range(0, 19) < 3);
            i_jump_addr    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
            i_imem_wr_en   = ($urandom_range(0, 4) == 0);
            i_imem_wr_addr = AW'($urandom);
            i_imem_wr_data = ($urandom_range(0, 63) == 0) ? 32'hFFFF_FFFF : $urandom;
            step();
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        i_enable = 1'b0; i_imem_wr_en = 1'b0; i_jump = 1'b0; i_stall = 1'b0;
        @(negedge i_clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
